// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU datapath widths and register-bank types.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_GPR    = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] word_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/reg_file_if.sv
// ============================================================================
//  Module      : reg_file_if
//  Description : Read/write port bundle of the general-purpose register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_if
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
);

    logic [ADDR_WIDTH-1:0] Ra;
    logic [ADDR_WIDTH-1:0] Rb;
    logic [ADDR_WIDTH-1:0] Rw;
    logic                  RegWr;
    logic [DATA_WIDTH-1:0] busW;
    logic [DATA_WIDTH-1:0] busA;
    logic [DATA_WIDTH-1:0] busB;

    modport master (
        output Ra,
        output Rb,
        output Rw,
        output RegWr,
        output busW,
        input  busA,
        input  busB
    );

    modport slave (
        input  Ra,
        input  Rb,
        input  Rw,
        input  RegWr,
        input  busW,
        output busA,
        output busB
    );

endinterface : reg_file_if

`default_nettype wire

// File: rtl/reg_file_read_mux.sv
// ============================================================================
//  Module      : reg_file_read_mux
//  Description : Combinational NUM_REGS:1 read selector with r0/range masking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_read_mux
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_REGS   = NUM_GPR,
    parameter int ZERO_R0    = 0
) (
    input  wire logic [NUM_REGS-1:0][DATA_WIDTH-1:0] i_regs,
    input  wire logic [ADDR_WIDTH-1:0]               i_addr,
    output logic      [DATA_WIDTH-1:0]               o_data
);

    // Unimplemented addresses never match any index and fall through to zero.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_addr == ADDR_WIDTH'(i)) begin
                o_data = ((ZERO_R0 != 0) && (i == 0)) ? '0 : i_regs[i];
            end
        end
    end

endmodule : reg_file_read_mux

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
//  Module      : reg_file
//  Description : General-purpose register bank, 2 async read ports, 1 write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_REGS   = NUM_GPR,
    parameter int ZERO_R0    = 0
) (
    input  wire logic   Clock,
    input  wire logic   Reset,
    reg_file_if.slave   bus
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
    logic [NUM_REGS-1:0]                 w_we;

    // One enable per register; r0 is never enabled when it is hard-wired.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign w_we[i] = bus.RegWr
                       && (bus.Rw == ADDR_WIDTH'(i))
                       && !((ZERO_R0 != 0) && (i == 0));

        always_ff @(posedge Clock) begin
            if (Reset) begin
                r_regs[i] <= '0;
            end else if (w_we[i]) begin
                r_regs[i] <= bus.busW;
            end
        end
    end

    reg_file_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ZERO_R0    (ZERO_R0)
    ) u_mux_a (
        .i_regs (r_regs),
        .i_addr (bus.Ra),
        .o_data (bus.busA)
    );

    reg_file_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ZERO_R0    (ZERO_R0)
    ) u_mux_b (
        .i_regs (r_regs),
        .i_addr (bus.Rb),
        .o_data (bus.busB)
    );

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
//  Module      : tb_reg_file
//  Description : Directed checks of reg_file in three configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;
    import cpu_pkg::*;

    logic      Clock = 1'b0;
    logic      Reset;
    reg_addr_t ra, rb, rw;
    logic      we;
    word_t     wd;

    int checks = 0;
    int errors = 0;
    word_t m [32];

    always #5 Clock = ~Clock;

    // dut0: plain; dut1: hard-wired r0; dut2: only 20 implemented registers
    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();
    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();
    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus2 ();

    assign bus0.Ra = ra; assign bus0.Rb = rb; assign bus0.Rw = rw;
    assign bus0.RegWr = we; assign bus0.busW = wd;
    assign bus1.Ra = ra; assign bus1.Rb = rb; assign bus1.Rw = rw;
    assign bus1.RegWr = we; assign bus1.busW = wd;
    assign bus2.Ra = ra; assign bus2.Rb = rb; assign bus2.Rw = rw;
    assign bus2.RegWr = we; assign bus2.busW = wd;

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32), .ZERO_R0(0))
        dut0 (.Clock(Clock), .Reset(Reset), .bus(bus0.slave));
    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32), .ZERO_R0(1))
        dut1 (.Clock(Clock), .Reset(Reset), .bus(bus1.slave));
    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(20), .ZERO_R0(0))
        dut2 (.Clock(Clock), .Reset(Reset), .bus(bus2.slave));

    typedef struct {
        logic      we;
        reg_addr_t rw;
        word_t     wd;
        reg_addr_t ra;
        reg_addr_t rb;
        word_t     ea;
        word_t     eb;
        word_t     za;
        word_t     zb;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic word_t expv(input int cfg, input reg_addr_t a);
        if (cfg == 1 && a == 5'd0) return 32'd0;
        if (cfg == 2 && a >= 5'd20) return 32'd0;
        return m[a];
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_pair(input string tag, input reg_addr_t a, input reg_addr_t b);
        ra = a;
        rb = b;
        #1;
        chk($sformatf("%s A0 ra=%0d", tag, a), bus0.busA, expv(0, a));
        chk($sformatf("%s B0 rb=%0d", tag, b), bus0.busB, expv(0, b));
        chk($sformatf("%s A1 ra=%0d", tag, a), bus1.busA, expv(1, a));
        chk($sformatf("%s B1 rb=%0d", tag, b), bus1.busB, expv(1, b));
        chk($sformatf("%s A2 ra=%0d", tag, a), bus2.busA, expv(2, a));
        chk($sformatf("%s B2 rb=%0d", tag, b), bus2.busB, expv(2, b));
    endtask

    task automatic wr(input reg_addr_t a, input word_t d);
        we = 1'b1;
        rw = a;
        wd = d;
        tick();
        m[a] = d;
        we = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < 32; i++) check_pair(tag, 5'(i), 5'(31 - i));
    endtask

    initial begin
        //            we    rw     wd      ra     rb     ea     eb     za     zb
        tbl[0] = '{1'b1, 5'd0, 32'd1,  5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[1] = '{1'b1, 5'd1, 32'd2,  5'd0, 5'd1, 32'd1, 32'd0, 32'd0, 32'd0};
        tbl[2] = '{1'b1, 5'd2, 32'd3,  5'd1, 5'd2, 32'd2, 32'd0, 32'd2, 32'd0};
        tbl[3] = '{1'b1, 5'd3, 32'd4,  5'd2, 5'd3, 32'd3, 32'd0, 32'd3, 32'd0};
        tbl[4] = '{1'b1, 5'd4, 32'd5,  5'd0, 5'd3, 32'd1, 32'd4, 32'd0, 32'd4};
        tbl[5] = '{1'b1, 5'd5, 32'd6,  5'd4, 5'd5, 32'd5, 32'd0, 32'd5, 32'd0};
        tbl[6] = '{1'b0, 5'd0, 32'd99, 5'd0, 5'd1, 32'd1, 32'd2, 32'd0, 32'd2};
        tbl[7] = '{1'b0, 5'd2, 32'd77, 5'd2, 5'd3, 32'd3, 32'd4, 32'd3, 32'd4};
        tbl[8] = '{1'b0, 5'd0, 32'd0,  5'd4, 5'd5, 32'd5, 32'd6, 32'd5, 32'd6};
        tbl[9] = '{1'b0, 5'd0, 32'd0,  5'd0, 5'd2, 32'd1, 32'd3, 32'd0, 32'd3};

        Reset = 1'b1; we = 1'b0; rw = '0; wd = '0; ra = '0; rb = '0;
        clear_model();
        tick();
        tick();
        Reset = 1'b0;
        sweep_zero("reset");

        // Directed writes: expected values are the reads seen before each edge.
        for (int v = 0; v < 10; v++) begin
            we = tbl[v].we; rw = tbl[v].rw; wd = tbl[v].wd;
            ra = tbl[v].ra; rb = tbl[v].rb;
            #1;
            chk($sformatf("tbl%0d A0", v), bus0.busA, tbl[v].ea);
            chk($sformatf("tbl%0d B0", v), bus0.busB, tbl[v].eb);
            chk($sformatf("tbl%0d A1", v), bus1.busA, tbl[v].za);
            chk($sformatf("tbl%0d B1", v), bus1.busB, tbl[v].zb);
            chk($sformatf("tbl%0d A2", v), bus2.busA, tbl[v].ea);
            chk($sformatf("tbl%0d B2", v), bus2.busB, tbl[v].eb);
            tick();
            if (tbl[v].we) m[tbl[v].rw] = tbl[v].wd;
        end
        we = 1'b0;

        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i));
        for (int i = 0; i < 32; i += 2) check_pair("sweep", 5'(i), 5'(i + 1));

        we = 1'b0; rw = 5'd7; wd = 32'hDEADBEEF;
        tick();
        check_pair("wrdis", 5'd7, 5'd7);

        ra = 5'd10; rb = 5'd11;
        wr(5'd12, 32'h0000_1234);
        check_pair("other", 5'd10, 5'd11);
        check_pair("other12", 5'd12, 5'd12);

        // Same-address read during write: old value before the edge, new after.
        ra = 5'd9; rb = 5'd9; we = 1'b1; rw = 5'd9; wd = 32'hA5A5A5A5;
        check_pair("coll_pre", 5'd9, 5'd9);
        tick();
        m[9] = 32'hA5A5A5A5;
        we = 1'b0;
        check_pair("coll_post", 5'd9, 5'd9);

        Reset = 1'b1; we = 1'b1; rw = 5'd3; wd = 32'h55;
        tick();
        Reset = 1'b0; we = 1'b0;
        clear_model();
        sweep_zero("rst_vs_wr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file

`default_nettype wire
